// File: rtl/alu.sv
// Single-cycle RV32 integer ALU with registered result and rd write flag.
// Optional ALU_M_EXT_EN macro adds MUL/MULH/MULHSU/MULHU (funct7 0000001).
module alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] c_out,
  output logic            rd_wr
);

  localparam int unsigned SHW      = 5;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] c_d, c_q;
  logic            rd_wr_d, rd_wr_q;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));

  // Shared integer op; alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic logic [XLEN-1:0] base_op(
    input logic [2:0]      f3,
    input logic            alt,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (f3)
      3'b000:  base_op = alt ? (a - b) : (a + b);
      3'b001:  base_op = a << sh;
      3'b010:  base_op = XLEN'($signed(a) < $signed(b));
      3'b011:  base_op = XLEN'(a < b);
      3'b100:  base_op = a ^ b;
      3'b101:  base_op = alt ? XLEN'($signed(a) >>> sh) : (a >> sh);
      3'b110:  base_op = a | b;
      default: base_op = a & b;
    endcase
  endfunction

`ifdef ALU_M_EXT_EN
  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN+1:0] mul_prod;
  logic [XLEN-1:0]          mul_res;

  // One signed (XLEN+1)x(XLEN+1) multiplier covers all four signedness variants.
  always_comb begin
    mul_a    = $signed({a_in[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010), a_in});
    mul_b    = $signed({b_in[XLEN-1] & (funct3 == 3'b001), b_in});
    mul_prod = (2*XLEN+2)'(mul_a) * (2*XLEN+2)'(mul_b);
    mul_res  = (funct3 == 3'b000) ? XLEN'(mul_prod) : XLEN'(mul_prod >> XLEN);
  end
`endif

  // Decode and compute; unsupported encodings leave result and write flag at zero.
  always_comb begin
    logic            valid;
    logic [XLEN-1:0] res;
    valid = 1'b0;
    res   = '0;
    case (opcode)
      OP_R: begin
        case (funct7)
          F7_BASE: begin
            valid = 1'b1;
            res   = base_op(funct3, 1'b0, a_in, b_in);
          end
          F7_ALT: begin
            valid = (funct3 == 3'b000) || (funct3 == 3'b101);
            res   = base_op(funct3, 1'b1, a_in, b_in);
          end
`ifdef ALU_M_EXT_EN
          7'b0000001: begin
            valid = !funct3[2];
            res   = mul_res;
          end
`endif
          default: valid = 1'b0;
        endcase
      end
      OP_I: begin
        case (funct3)
          3'b001:  valid = (funct7 == F7_BASE);
          3'b101:  valid = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: valid = 1'b1;
        endcase
        res = base_op(funct3, (funct3 == 3'b101) && instr[30], a_in, imm_i);
      end
      OP_LUI: begin
        valid = 1'b1;
        res   = imm_u;
      end
      OP_AUIPC: begin
        valid = 1'b1;
        res   = a_in + imm_u;
      end
      default: valid = 1'b0;
    endcase
    c_d     = valid ? res : '0;
    rd_wr_d = valid && (rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      rd_wr_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      rd_wr_q <= rd_wr_d;
    end
  end

  assign c_out = c_q;
  assign rd_wr = rd_wr_q;

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against a behavioural RV32 ALU model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] c_out;
  logic        rd_wr;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};

  alu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .instr (instr),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_out (c_out),
    .rd_wr (rd_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  // Reference: instruction semantics written out mnemonic by mnemonic.
  function automatic void ref_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic wr);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] res;
    logic        ok;
    longint      sp;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = {{20{ins[31]}}, ins[31:20]};
    res = 32'h0;
    ok  = 1'b1;
    sp  = 0;
    if (op == 7'b0110011) begin
      case ({f7, f3})
        {7'h00, 3'd0}: res = a + b;
        {7'h20, 3'd0}: res = a - b;
        {7'h00, 3'd1}: res = a << b[4:0];
        {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: res = (a < b) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: res = a ^ b;
        {7'h00, 3'd5}: res = a >> b[4:0];
        {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
        {7'h00, 3'd6}: res = a | b;
        {7'h00, 3'd7}: res = a & b;
`ifdef ALU_M_EXT_EN
        {7'h01, 3'd0}: res = a * b;
        {7'h01, 3'd1}: begin sp = longint'($signed(a)) * longint'($signed(b)); res = 32'(sp >>> 32); end
        {7'h01, 3'd2}: begin sp = longint'($signed(a)) * longint'({32'h0, b}); res = 32'(sp >>> 32); end
        {7'h01, 3'd3}: begin sp = longint'({32'h0, a}) * longint'({32'h0, b}); res = 32'(sp >> 32); end
`endif
        default: ok = 1'b0;
      endcase
    end else if (op == 7'b0010011) begin
      case (f3)
        3'd0: res = a + imm;
        3'd1: begin ok = (f7 == 7'h00); res = a << ins[24:20]; end
        3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: res = (a < imm) ? 32'd1 : 32'd0;
        3'd4: res = a ^ imm;
        3'd5: begin
          if (f7 == 7'h00)      res = a >> ins[24:20];
          else if (f7 == 7'h20) res = $signed(a) >>> ins[24:20];
          else                  ok = 1'b0;
        end
        3'd6: res = a | imm;
        default: res = a & imm;
      endcase
    end else if (op == 7'b0110111) begin
      res = {ins[31:12], 12'h000};
    end else if (op == 7'b0010111) begin
      res = a + {ins[31:12], 12'h000};
    end else begin
      ok = 1'b0;
    end
    c  = ok ? res : 32'h0;
    wr = ok && (ins[11:7] != 5'd0);
  endfunction

  task automatic do_op(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ec;
    logic        ew;
    @(negedge clk);
    instr = ins;
    a_in  = a;
    b_in  = b;
    ref_alu(ins, a, b, ec, ew);
    @(posedge clk);
    #1;
    check({tag, "_c"}, c_out, ec);
    check({tag, "_wr"}, 32'(rd_wr), 32'(ew));
  endtask

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rdf;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: op = 7'b0110011;
      4, 5, 6:    op = 7'b0010011;
      7:          op = 7'b0110111;
      8:          op = 7'b0010111;
      default:    op = 7'($urandom());
    endcase
    case ($urandom_range(0, 4))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      3:       f7 = 7'h01;
      default: f7 = 7'($urandom());
    endcase
    rdf = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom());
    return {f7, 10'($urandom()), 3'($urandom()), rdf, op};
  endfunction

  initial begin
    rst_n = 1'b0;
    instr = 32'h0020_80B3;
    a_in  = 32'h1111_1111;
    b_in  = 32'h2222_2222;
    #1;
    check("rst_c", c_out, 32'h0);
    check("rst_wr", 32'(rd_wr), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_c", c_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_x1", 32'h0020_80B3, 32'hFFFF_FFFF, 32'h0000_0002);
    check("add_x1_vec", c_out, 32'h0000_0001);
    do_op("sub_x0", 32'h4020_8033, 32'h0000_0005, 32'h0000_0007);
    check("sub_x0_vec", c_out, 32'hFFFF_FFFE);
    check("sub_x0_wr_vec", 32'(rd_wr), 32'h0);
    do_op("sra", 32'h4020_D0B3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("sra_vec", c_out, 32'hFFFF_FFFF);
    do_op("srl", 32'h0020_D0B3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("srl_vec", c_out, 32'h0000_0001);
    do_op("slt", 32'h0020_A0B3, 32'h8000_0000, 32'h0000_0001);
    check("slt_vec", c_out, 32'h1);
    do_op("sltu", 32'h0020_B0B3, 32'h8000_0000, 32'h0000_0001);
    check("sltu_vec", c_out, 32'h0);
    do_op("slt_b", 32'h0020_A0B3, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_b_vec", c_out, 32'h1);
    do_op("sltu_b", 32'h0020_B0B3, 32'h8000_0000, 32'h7FFF_FFFF);
    check("sltu_b_vec", c_out, 32'h0);
    do_op("sra31", 32'h4020_D0B3, 32'h8000_0000, 32'h0000_001F);
    check("sra31_vec", c_out, 32'hFFFF_FFFF);
    do_op("sll0", 32'h0020_90B3, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    check("sll0_vec", c_out, 32'hDEAD_BEEF);
    do_op("srai31", 32'h41F0_D093, 32'h8000_0000, 32'h0);
    do_op("addi_neg", 32'hFFF0_8093, 32'h0000_0000, 32'h0);
    do_op("lui", 32'hABCD_E0B7, 32'h1234_5678, 32'h0);
    check("lui_vec", c_out, 32'hABCD_E000);
    do_op("auipc", 32'h0000_1097, 32'h0000_0100, 32'h0);
    check("auipc_vec", c_out, 32'h0000_1100);
    do_op("bad_op", 32'h0020_8083, 32'h5, 32'h6);
    check("bad_op_vec", c_out, 32'h0);
    do_op("bad_f7", 32'h4020_90B3, 32'h5, 32'h6);
    do_op("mul", 32'h0220_80B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_M_EXT_EN
    check("mul_vec", c_out, 32'h0000_0001);
`else
    check("mul_vec", c_out, 32'h0);
`endif
    do_op("mulhu", 32'h0220_B0B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_M_EXT_EN
    check("mulhu_vec", c_out, 32'hFFFF_FFFE);
`else
    check("mulhu_vec", c_out, 32'h0);
`endif
    do_op("div", 32'h0220_C0B3, 32'h10, 32'h2);

    // Asynchronous reset mid-cycle, then an in-flight op held across reset is dropped.
    do_op("pre_rst", 32'h0020_80B3, 32'h0000_1000, 32'h0000_0234);
    check("pre_rst_vec", c_out, 32'h0000_1234);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_c", c_out, 32'h0);
    check("async_rst_wr", 32'(rd_wr), 32'h0);
    @(posedge clk);
    #1;
    check("rst_drop_c", c_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 32'h0020_80B3, 32'h0000_0040, 32'h0000_0002);

    for (int i = 0; i < 400; i++) begin
      do_op($sformatf("rnd%0d", i), rand_instr(), pick_operand(), pick_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: instr  input  32  RV32 instruction word (opcode [6:0], rd [11:7], funct3 [14:12], funct7 [31:25]).
REQ-005 SHALL have port: a_in  input  XLEN  operand A (rs1 value; PC for AUIPC).
REQ-006 SHALL have port: b_in  input  XLEN  operand B (rs2 value, R-type only).
REQ-007 SHALL have port: c_out  output  XLEN  registered result.
REQ-008 SHALL have port: rd_wr  output  1  registered flag: result is to be written to rd.

Function
REQ-009 SHALL register c_out and rd_wr on rising clk; latency exactly 1 cycle from inputs to outputs; no handshake, one new operation accepted per cycle.
REQ-010 R-type (opcode 0110011, funct7 0000000/0100000) SHALL compute: ADD a+b; SUB (funct7[5]=1, funct3 000) a-b; AND; OR; XOR; SLT signed compare -> 1/0; SLTU unsigned compare -> 1/0; SLL a<<b[4:0]; SRL logical a>>b[4:0]; SRA (funct7[5]=1, funct3 101) arithmetic a>>>b[4:0].
REQ-011 Add/subtract SHALL wrap modulo 2^XLEN; carry/overflow discarded.
REQ-012 Shifts SHALL use only the low 5 bits of the shift amount; upper bits ignored.
REQ-013 I-type ALU (opcode 0010011) SHALL use sign-extended instr[31:20] as operand B for ADDI/SLTI/SLTIU/XORI/ORI/ANDI; SLLI/SRLI/SRAI shamt = instr[24:20], SRAI selected by instr[30].
REQ-014 LUI (0110111) SHALL produce {instr[31:12], 12'b0}; AUIPC (0010111) SHALL produce a_in + {instr[31:12], 12'b0}.
REQ-015 rd_wr SHALL be 1 for every supported R-type, I-type ALU, LUI, AUIPC operation whose rd field is nonzero; 0 when rd = 0.
REQ-016 Any other opcode, or unsupported funct3/funct7 combination, SHALL produce c_out = 0 and rd_wr = 0.
REQ-017 Boundary: SLT(0x80000000, 0x7FFFFFFF) = 1; SLTU same operands = 0; SRA of 0x80000000 by 31 = 0xFFFFFFFF; shift by 0 returns a_in unchanged.

Reset
REQ-018 SHALL, while rst_n = 0, asynchronously force c_out = 0 and rd_wr = 0.
REQ-019 SHALL resume normal 1-cycle operation on the first rising clk after rst_n deasserts; an operation in flight when reset asserts is discarded.

Configuration
REQ-020 Macro ALU_M_EXT_EN: when defined, R-type funct7 0000001 SHALL support MUL (low 32 bits), MULH (signed x signed high), MULHSU (signed x unsigned high), MULHU (unsigned high) for funct3 000-011, rd_wr per REQ-015; funct3 100-111 (divide/remainder) SHALL give c_out = 0, rd_wr = 0.
REQ-021 When ALU_M_EXT_EN is not defined, funct7 0000001 SHALL be treated as unsupported per REQ-016 and no multiplier logic SHALL be synthesized.

Verification
REQ-022 instr 0x002080B3 (add x1), a=0xFFFFFFFF, b=0x00000002 -> next cycle c_out=0x00000001, rd_wr=1.
REQ-023 instr 0x40208033 (sub x0), a=0x00000005, b=0x00000007 -> c_out=0xFFFFFFFE, rd_wr=0 (rd=x0).
REQ-024 instr 0x4020D0B3 (sra x1), a=0x80000000, b=0xFFFFFFFF -> c_out=0xFFFFFFFF; same with 0x0020D0B3 (srl) -> 0x00000001.
REQ-025 instr 0x0020A0B3 (slt) / 0x0020B0B3 (sltu), a=0x80000000, b=0x00000001 -> 1 / 0 respectively.
REQ-026 Drive ADD result 0x1234, then pull rst_n low mid-cycle -> c_out=0, rd_wr=0 immediately, before next clk edge.
REQ-027 With ALU_M_EXT_EN: instr 0x022080B3 (mul x1), a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001; same as mulhu (0x0220B0B3) -> 0xFFFFFFFE; without macro -> c_out=0, rd_wr=0.
